spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
- SPI master transfer sequencer. It enables the baud divider for the duration of one word, counts half-SCK ticks, and drives SCK/CS_n/MOSI.
- It shifts in MISO and hands the received word back through a start/busy/done handshake.
- It sits between the host register interface and the divider block; the divider's half-period pulse is the only timing source.

Parameters:
- DATA_W, 8, bits per transfer (range 4..32).
- EDGE_W, 6, width of the edge counter; must hold 2*DATA_W.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a transfer; sampled only in IDLE.
- cpol  in  1  SCK idle level; latched at start.
- cpha  in  1  clock phase; latched at start.
- tx_data  in  DATA_W  word to send, MSB first; latched at start.
- rx_data  out  DATA_W  last received word; updated with done.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of transfer.
- brd_en  out  1  enable to the divider; low resets the divider.
- brd_tick  in  1  one-cycle pulse per SCK half-period from the divider.
- sclk  out  1  SPI clock.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset values: rx_data=0, busy=0, done=0, brd_en=0, sclk=0, cs_n=1, mosi=0, state=IDLE, edge_cnt=0. Reset wins over every other event, including mid-transfer: CS_n rises and brd_en drops on the next edge, and no done pulse is produced.
- States: IDLE, SETUP, SHIFT, HOLD, FINISH.
- IDLE:
  - sclk <= cpol each cycle.
  - brd_tick is ignored.
  - On start=1, the next cycle enters SETUP with: cs_n=0, busy=1, brd_en=1, shreg=tx_data, cpol/cpha latched, edge_cnt=0, mosi=tx_data[DATA_W-1].
- SETUP:
  - Waits for the first brd_tick; this guarantees at least one half-period of CS setup.
  - On brd_tick, go to SHIFT with no SCK edge in that cycle.
- SHIFT:
  - Each brd_tick toggles sclk and increments edge_cnt.
  - Even edge_cnt = leading edge; odd = trailing edge.
  - cpha=0: sample miso into shreg LSB on leading edges; shift shreg left and drive the new MSB on mosi on trailing edges. The last trailing edge does not change mosi.
  - cpha=1: on leading edges, drive mosi from the shreg MSB (first edge drives tx bit DATA_W-1), then shift; sample on trailing edges.
  - When the tick that makes edge_cnt = 2*DATA_W arrives, go to HOLD. sclk is then back at cpol.
- HOLD: the next brd_tick goes to FINISH (one half-period CS hold).
- FINISH (exactly one cycle):
  - cs_n=1, brd_en=0, done=1, rx_data=shreg, busy=0.
  - Return to IDLE.
  - A start asserted in this cycle is ignored; start is accepted from the following cycle.
- start while busy=1 is ignored; there is no queuing.
- tx_data/cpol/cpha changes while busy have no effect on the current transfer.
- A brd_tick every cycle (divider at minimum) must work: SHIFT then lasts exactly 2*DATA_W cycles.
- Simultaneous brd_tick and reset: reset wins.

Decomposition:
- Package spi_pkg holds:
  - the state encoding enum (IDLE, SETUP, SHIFT, HOLD, FINISH);
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - the default DATA_W.
- One sub-module is natural: spi_shift_reg (load, shift-left, sample-in, MSB out), parameterized by DATA_W. The FSM and edge counter stay in spi_xfer_ctrl.

Test Plan:
- Mode 0, tx_data=0xA5, miso looped to mosi, brd_tick every 4 cycles -> 16 sclk edges, first rising edge sees mosi=1, rx_data=0xA5, done pulses once, cs_n low for exactly (1+16+1)*4 cycles plus one.
- Mode 3, tx_data=0x00, miso driven 0x3C MSB-first on falling edges -> sclk idles 1, rx_data=0x3C, mosi constant 0.
- start re-pulsed at edge 5 with tx_data=0xFF during a 0x12 transfer -> transfer completes with 0x12 on mosi; a single done pulse.
- Reset asserted at edge 9 -> the next cycle has cs_n=1, brd_en=0, busy=0, sclk=0; no done; rx_data keeps its previous value.
- brd_tick held high, two back-to-back transfers (0x81 then 0x7E), start asserted the cycle after done -> both complete and rx_data matches loopback; SHIFT is 16 cycles each.
- brd_tick pulses while IDLE, and start with cpol=1 -> no sclk toggles and cs_n stays 1 while IDLE; sclk=1 in IDLE after the cpol change.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer sequencer.
package spi_pkg;

    localparam int DATA_W_DEFAULT = 8;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } xfer_state_t;

    function automatic logic is_leading_edge(input logic edge_lsb);
        return ~edge_lsb;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host handshake, divider link and SPI pins of the transfer sequencer.
interface spi_xfer_ctrl_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              brd_en;
    logic              brd_tick;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, cpol, cpha, tx_data, brd_tick, miso,
        output rx_data, busy, done, brd_en, sclk, cs_n, mosi
    );

    modport slave (
        output start, cpol, cpha, tx_data, brd_tick, miso,
        input  rx_data, busy, done, brd_en, sclk, cs_n, mosi
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Transfer shift register: parallel load, shift-left with serial input, LSB sample.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              shift_in,
    input  logic              sample,
    input  logic              sample_in,
    output logic [DATA_W-1:0] q,
    output logic              msb,
    output logic              next_msb
);

    logic [DATA_W-1:0] q_r;

    // Load has priority over shift, shift over LSB sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= {DATA_W{1'b0}};
        end else if (load) begin
            q_r <= load_data;
        end else if (shift) begin
            q_r <= {q_r[DATA_W-2:0], shift_in};
        end else if (sample) begin
            q_r[0] <= sample_in;
        end else begin
            q_r <= q_r;
        end
    end

    assign q        = q_r;
    assign msb      = q_r[DATA_W-1];
    assign next_msb = q_r[DATA_W-2];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: paces SCK from the divider tick, shifts one word per start.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int EDGE_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    spi_xfer_ctrl_if.master bus
);

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = {{(EDGE_W-1){1'b0}}, 1'b1};

    xfer_state_t       state_r, state_s;
    logic [EDGE_W-1:0] edge_cnt_r, edge_cnt_s;
    logic              cpol_r, cpol_s;
    logic              cpha_r, cpha_s;
    logic              sclk_r, sclk_s;
    logic              cs_n_r, cs_n_s;
    logic              mosi_r, mosi_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              brd_en_r, brd_en_s;
    logic              sample_r, sample_s;
    logic [DATA_W-1:0] rx_data_r, rx_data_s;

    logic              sr_load_s, sr_shift_s, sr_shift_in_s, sr_sample_s;
    logic [DATA_W-1:0] sr_q_s;
    logic              sr_msb_s, sr_next_msb_s;
    logic              leading_s, last_edge_s;

    spi_shift_reg #(.DATA_W(DATA_W)) u_shreg (
        .clock     (clock),
        .reset     (reset),
        .load      (sr_load_s),
        .load_data (bus.tx_data),
        .shift     (sr_shift_s),
        .shift_in  (sr_shift_in_s),
        .sample    (sr_sample_s),
        .sample_in (bus.miso),
        .q         (sr_q_s),
        .msb       (sr_msb_s),
        .next_msb  (sr_next_msb_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        edge_cnt_s    = edge_cnt_r;
        cpol_s        = cpol_r;
        cpha_s        = cpha_r;
        sclk_s        = sclk_r;
        cs_n_s        = cs_n_r;
        mosi_s        = mosi_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        brd_en_s      = brd_en_r;
        rx_data_s     = rx_data_r;
        sample_s      = sample_r;
        sr_load_s     = 1'b0;
        sr_shift_s    = 1'b0;
        sr_shift_in_s = 1'b0;
        sr_sample_s   = 1'b0;
        leading_s     = is_leading_edge(edge_cnt_r[0]);
        last_edge_s   = (edge_cnt_r == LAST_EDGE);

        case (state_r)
            IDLE: begin
                sclk_s = bus.cpol;
                if (bus.start) begin
                    state_s    = SETUP;
                    cs_n_s     = 1'b0;
                    busy_s     = 1'b1;
                    brd_en_s   = 1'b1;
                    sr_load_s  = 1'b1;
                    cpol_s     = bus.cpol;
                    cpha_s     = bus.cpha;
                    edge_cnt_s = {EDGE_W{1'b0}};
                    mosi_s     = bus.tx_data[DATA_W-1];
                end else begin
                    cs_n_s   = 1'b1;
                    busy_s   = 1'b0;
                    brd_en_s = 1'b0;
                end
            end
            SETUP: begin
                if (bus.brd_tick) begin
                    state_s = SHIFT;
                end else begin
                    state_s = SETUP;
                end
            end
            SHIFT: begin
                if (bus.brd_tick) begin
                    sclk_s     = ~sclk_r;
                    edge_cnt_s = edge_cnt_r + EDGE_ONE;
                    // cpha=0 holds the sampled bit aside so tx bit 0 survives until it is shifted out
                    if (leading_s) begin
                        if (cpha_r) begin
                            mosi_s     = sr_msb_s;
                            sr_shift_s = 1'b1;
                        end else begin
                            sample_s = bus.miso;
                        end
                    end else begin
                        if (cpha_r) begin
                            sr_sample_s = 1'b1;
                        end else begin
                            sr_shift_s    = 1'b1;
                            sr_shift_in_s = sample_r;
                            if (!last_edge_s) begin
                                mosi_s = sr_next_msb_s;
                            end else begin
                                mosi_s = mosi_r;
                            end
                        end
                    end
                    if (last_edge_s) begin
                        state_s = HOLD;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            HOLD: begin
                if (bus.brd_tick) begin
                    state_s   = FINISH;
                    cs_n_s    = 1'b1;
                    brd_en_s  = 1'b0;
                    done_s    = 1'b1;
                    busy_s    = 1'b0;
                    rx_data_s = sr_q_s;
                    sclk_s    = cpol_r;
                end else begin
                    state_s = HOLD;
                end
            end
            FINISH: begin
                state_s = IDLE;
                sclk_s  = cpol_r;
            end
            default: begin
                state_s  = IDLE;
                cs_n_s   = 1'b1;
                busy_s   = 1'b0;
                brd_en_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            edge_cnt_r <= {EDGE_W{1'b0}};
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            sclk_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            brd_en_r   <= 1'b0;
            sample_r   <= 1'b0;
            rx_data_r  <= {DATA_W{1'b0}};
        end else begin
            edge_cnt_r <= edge_cnt_s;
            cpol_r     <= cpol_s;
            cpha_r     <= cpha_s;
            sclk_r     <= sclk_s;
            cs_n_r     <= cs_n_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            brd_en_r   <= brd_en_s;
            sample_r   <= sample_s;
            rx_data_r  <= rx_data_s;
        end
    end

    assign bus.rx_data = rx_data_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.brd_en  = brd_en_r;
    assign bus.sclk    = sclk_r;
    assign bus.cs_n    = cs_n_r;
    assign bus.mosi    = mosi_r;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench: a protocol-level SPI slave plus divider model, expected words queued at start.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    localparam int DW = 8;
    localparam int EW = 6;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        logic          cpol;
        int            period;
        int            cs_low;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_xfer_ctrl_if #(.DATA_W(DW)) bus ();

    spi_xfer_ctrl #(.DATA_W(DW), .EDGE_W(EW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    int n_issued = 0;
    int n_aborted = 0;
    int done_cnt = 0;

    // stimulus-side controls
    logic          tick_high = 1'b0;
    logic          noise = 1'b0;
    logic          loop_en = 1'b0;
    int            div_n = 4;
    logic [DW-1:0] slv_pat = '0;
    logic          m_cpol = 1'b0;
    logic          m_cpha = 1'b0;

    // divider model: counter cleared while brd_en is low, registered tick every div_n cycles
    int   div_cnt = 0;
    logic div_tick_r = 1'b0;
    always @(posedge clock) begin
        if (bus.brd_en !== 1'b1) begin
            div_cnt    <= 0;
            div_tick_r <= 1'b0;
        end else begin
            div_tick_r <= (div_cnt == div_n - 1);
            div_cnt    <= (div_cnt == div_n - 1) ? 0 : div_cnt + 1;
        end
    end

    logic slave_miso = 1'b0;
    always_comb bus.brd_tick = tick_high | noise | div_tick_r;
    always_comb bus.miso = loop_en ? bus.mosi : slave_miso;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // monitor: SPI slave behaviour plus scoreboard pop on done
    logic          prev_cs_n = 1'b1;
    logic          prev_sclk = 1'b0;
    logic          prev_done = 1'b0;
    logic [DW-1:0] slv_in = '0;
    int            oidx = 0;
    int            edges = 0;
    int            cs_low = 0;
    int            mosi_ones = 0;
    int            cyc = 0;
    int            first_t = -1;
    int            last_t = -1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                edges = 0;
                cs_low = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_cs_n && !bus.cs_n) begin
                    edges = 0; cs_low = 0; mosi_ones = 0; slv_in = '0;
                    first_t = -1; last_t = -1;
                    chk("busy_at_cs_fall", bus.busy, 1);
                    chk("brd_en_at_cs_fall", bus.brd_en, 1);
                    if (!m_cpha) begin
                        slave_miso = slv_pat[DW-1];
                        oidx = DW - 2;
                    end else begin
                        oidx = DW - 1;
                    end
                end else if (!prev_cs_n && !bus.cs_n && bus.sclk != prev_sclk) begin
                    if (first_t < 0) first_t = cyc;
                    last_t = cyc;
                    edges++;
                    if (bus.sclk != m_cpol) begin
                        if (!m_cpha) begin
                            slv_in = {slv_in[DW-2:0], bus.mosi};
                        end else begin
                            if (oidx >= 0) slave_miso = slv_pat[oidx];
                            oidx--;
                        end
                    end else begin
                        if (!m_cpha) begin
                            if (oidx >= 0) slave_miso = slv_pat[oidx];
                            oidx--;
                        end else begin
                            slv_in = {slv_in[DW-2:0], bus.mosi};
                        end
                    end
                end
                if (!bus.cs_n) begin
                    cs_low++;
                    if (bus.mosi) mosi_ones++;
                end
                if (bus.done) begin
                    done_cnt++;
                    chk("done_width", prev_done, 0);
                    chk("pending_at_done", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rx_data", bus.rx_data, e.rx);
                        chk("slave_rx", slv_in, e.tx);
                        chk("sclk_edges", edges, 2 * DW);
                        chk("cs_low_cycles", cs_low, e.cs_low);
                        chk("shift_span", last_t - first_t, (2 * DW - 1) * e.period);
                        chk("sclk_idle_level", bus.sclk, e.cpol);
                        chk("cs_n_at_done", bus.cs_n, 1);
                        chk("busy_at_done", bus.busy, 0);
                        chk("brd_en_at_done", bus.brd_en, 0);
                        if (e.tx == '0) chk("mosi_all_zero", mosi_ones, 0);
                    end
                end
                if (!prev_cs_n && bus.cs_n) edges = 0;
            end
            prev_cs_n = bus.cs_n;
            prev_sclk = bus.sclk;
            prev_done = bus.done;
        end
    end

    task automatic issue(input logic [DW-1:0] tx, input logic [DW-1:0] pat, input logic [1:0] mode,
                         input logic lb, input int n, input logic th);
        exp_t e;
        tick_high = th;
        div_n     = n;
        loop_en   = lb;
        slv_pat   = pat;
        m_cpol    = mode[1];
        m_cpha    = mode[0];
        e.rx      = lb ? tx : pat;
        e.tx      = tx;
        e.cpol    = mode[1];
        e.period  = th ? 1 : n;
        e.cs_low  = th ? (2 * DW + 2) : ((2 * DW + 2) * n + 1);
        exp_q.push_back(e);
        n_issued++;
        bus.cpol    = mode[1];
        bus.cpha    = mode[0];
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (bus.done !== 1'b1 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk("done_within_budget", k < 3000, 1);
        @(negedge clock);
    endtask

    task automatic wait_edges(input int target);
        int k = 0;
        while (edges < target && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk("edge_wait_budget", k < 3000, 1);
    endtask

    initial begin
        logic [DW-1:0] tx, pat;
        logic [1:0]    mode;
        logic          lb, th;
        int            n;

        bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.tx_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_brd_en", bus.brd_en, 0);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_mosi", bus.mosi, 0);
        reset = 1'b0;
        @(negedge clock);

        // mode 0 loopback, divider every 4 cycles
        issue(8'hA5, 8'h00, SPI_MODE0, 1'b1, 4, 1'b0);
        wait_done();
        // mode 3, slave returns 0x3C, all-zero transmit
        issue(8'h00, 8'h3C, SPI_MODE3, 1'b0, 3, 1'b0);
        wait_done();
        // start re-pulsed mid-transfer with other data is ignored
        issue(8'h12, 8'hC3, SPI_MODE0, 1'b0, 4, 1'b0);
        wait_edges(5);
        bus.tx_data = 8'hFF;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        // leaves rx_data at zero before the abort test
        issue(8'h00, 8'h00, SPI_MODE0, 1'b1, 2, 1'b0);
        wait_done();

        // reset in the middle of a transfer, ticks every cycle
        issue(8'h5A, 8'h96, SPI_MODE2, 1'b0, 1, 1'b0);
        wait_edges(9);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_cs_n", bus.cs_n, 1);
        chk("abort_brd_en", bus.brd_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rx_data", bus.rx_data, 0);
        reset = 1'b0;
        exp_q.delete();
        n_aborted++;
        @(negedge clock);

        // ticks while idle with cpol=1: no toggles, no chip select
        bus.cpol = 1'b1;
        for (int i = 0; i < 12; i++) begin
            noise = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("idle_sclk", bus.sclk, 1);
            chk("idle_cs_n", bus.cs_n, 1);
            chk("idle_brd_en", bus.brd_en, 0);
        end
        noise = 1'b0;

        // back-to-back with brd_tick held high
        issue(8'h81, 8'h00, SPI_MODE0, 1'b1, 1, 1'b1);
        wait_done();
        issue(8'h7E, 8'h00, SPI_MODE0, 1'b1, 1, 1'b1);
        wait_done();

        for (int i = 0; i < 12; i++) begin
            tx   = DW'($urandom);
            pat  = DW'($urandom);
            mode = 2'($urandom_range(0, 3));
            lb   = 1'($urandom_range(0, 1));
            th   = ($urandom_range(0, 3) == 0);
            n    = $urandom_range(1, 5);
            issue(tx, pat, mode, lb, n, th);
            wait_done();
        end
        tick_high = 1'b0;

        repeat (4) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", done_cnt, n_issued - n_aborted);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
